// File: rtl/panda_pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : panda_pc_unit
// Purpose  : Program-counter generator for the Panda fetch stage. Issues the
//            fetch address with a valid/ready handshake. Arbitrates trap, mret,
//            jump and branch redirects, supports optional 2-byte increments,
//            flags misaligned jump/branch targets, and gates fetch issue with a
//            BOOT/RUN/HALTED state machine.
// Ports    : clk_i, rst_ni (sync, active-low)
//            fetch_ready_i, compressed_i       - handshake / instruction size
//            branch_i/branch_target_i, jump_i/jump_target_i,
//            trap_i/trap_vector_i, mret_i/epc_i - redirect sources
//            halt_i, resume_i                  - run control
//            pc_valid_o, pc_o, pc_inc_o        - fetch request
//            redirect_o, misaligned_o, misaligned_addr_o - event pulses
// Revision : 1.0 - initial release
// ============================================================================
module panda_pc_unit #(
  parameter int unsigned      Width        = 32,
  parameter logic [Width-1:0] ResetVector  = '0,
  parameter bit               CompressedEn = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             fetch_ready_i,
  input  logic             compressed_i,
  input  logic             branch_i,
  input  logic [Width-1:0] branch_target_i,
  input  logic             jump_i,
  input  logic [Width-1:0] jump_target_i,
  input  logic             trap_i,
  input  logic [Width-1:0] trap_vector_i,
  input  logic             mret_i,
  input  logic [Width-1:0] epc_i,
  input  logic             halt_i,
  input  logic             resume_i,
  output logic             pc_valid_o,
  output logic [Width-1:0] pc_o,
  output logic [Width-1:0] pc_inc_o,
  output logic             redirect_o,
  output logic             misaligned_o,
  output logic [Width-1:0] misaligned_addr_o
);

  localparam logic [1:0] ST_BOOT   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  // Bits that must be zero in a legal target address.
  localparam logic [Width-1:0] ALIGN_MASK = CompressedEn ? {{(Width-1){1'b0}}, 1'b1}
                                                         : {{(Width-2){1'b0}}, 2'b11};
  localparam logic [Width-1:0] INC_2 = {{(Width-3){1'b0}}, 3'd2};
  localparam logic [Width-1:0] INC_4 = {{(Width-3){1'b0}}, 3'd4};

  logic [1:0]       state_q, state_d;
  logic [Width-1:0] pc_q, pc_d;
  logic             pc_valid_q, pc_valid_d;
  logic             redirect_q, redirect_d;
  logic             misaligned_q, misaligned_d;
  logic [Width-1:0] mis_addr_q, mis_addr_d;

  logic [Width-1:0] inc_step;
  logic             jump_mis;
  logic             branch_mis;

  assign inc_step   = (CompressedEn && compressed_i) ? INC_2 : INC_4;
  assign pc_inc_o   = pc_q + inc_step;
  assign jump_mis   = |(jump_target_i & ALIGN_MASK);
  assign branch_mis = |(branch_target_i & ALIGN_MASK);

  // PC source selection: fixed priority trap > mret > jump > branch > sequential.
  // A misaligned jump/branch consumes its priority slot, so a lower-priority
  // request in the same cycle is not used as a fallback.
  always_comb begin
    pc_d         = pc_q;
    redirect_d   = 1'b0;
    misaligned_d = 1'b0;
    mis_addr_d   = mis_addr_q;
    if (trap_i) begin
      pc_d       = trap_vector_i & ~ALIGN_MASK;
      redirect_d = 1'b1;
    end else if (mret_i) begin
      pc_d       = epc_i & ~ALIGN_MASK;
      redirect_d = 1'b1;
    end else if (jump_i) begin
      if (jump_mis) begin
        misaligned_d = 1'b1;
        mis_addr_d   = jump_target_i;
      end else begin
        pc_d       = jump_target_i;
        redirect_d = 1'b1;
      end
    end else if (branch_i) begin
      if (branch_mis) begin
        misaligned_d = 1'b1;
        mis_addr_d   = branch_target_i;
      end else begin
        pc_d       = branch_target_i;
        redirect_d = 1'b1;
      end
    end else if ((state_q == ST_RUN) && fetch_ready_i) begin
      // Handshake completed: advance, even if a halt lands this cycle.
      pc_d = pc_inc_o;
    end
  end

  // Run control. Trap forces RUN from any state; halt beats resume.
  always_comb begin
    state_d = state_q;
    if (trap_i) begin
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_BOOT:   state_d = ST_RUN;
        ST_RUN:    state_d = halt_i ? ST_HALTED : ST_RUN;
        ST_HALTED: state_d = (resume_i && !halt_i) ? ST_RUN : ST_HALTED;
        default:   state_d = ST_BOOT;
      endcase
    end
    pc_valid_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= ST_BOOT;
      pc_q         <= ResetVector;
      pc_valid_q   <= 1'b0;
      redirect_q   <= 1'b0;
      misaligned_q <= 1'b0;
      mis_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pc_valid_q   <= pc_valid_d;
      redirect_q   <= redirect_d;
      misaligned_q <= misaligned_d;
      mis_addr_q   <= mis_addr_d;
    end
  end

  assign pc_o              = pc_q;
  assign pc_valid_o        = pc_valid_q;
  assign redirect_o        = redirect_q;
  assign misaligned_o      = misaligned_q;
  assign misaligned_addr_o = mis_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_panda_pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_panda_pc_unit
// Purpose  : Self-checking bench for panda_pc_unit. Two instances share the
//            stimulus: dut0 (4-byte only) and dut1 (compressed enabled), both
//            with ResetVector 0x100.
// Revision : 1.0 - initial release
// ============================================================================
module tb_panda_pc_unit;

  typedef struct {
    bit          rst_n, rdy, cmp, tr, mr, jp, br, hl, rs;
    logic [31:0] tv, ep, jt, bt;
  } stim_t;

  typedef struct {
    string       name;
    stim_t       s;
    logic [31:0] pc;
    bit          valid, redir, mis;
    logic [31:0] maddr;
  } vec_t;

  typedef enum int {M_BOOT, M_RUN, M_HALT} mst_t;
  typedef struct {
    mst_t        st;
    logic [31:0] pc;
    bit          redir, mis;
    logic [31:0] maddr;
  } model_t;

  logic clk;
  stim_t cur;
  model_t m0, m1;
  int n_chk, n_fail;
  vec_t tbl[$];

  logic [31:0] pc0, inc0, ma0, pc1, inc1, ma1;
  logic        v0, r0, mi0, v1, r1, mi1;

  panda_pc_unit #(.Width(32), .ResetVector(32'h100), .CompressedEn(1'b0)) dut0 (
    .clk_i(clk), .rst_ni(cur.rst_n), .fetch_ready_i(cur.rdy), .compressed_i(cur.cmp),
    .branch_i(cur.br), .branch_target_i(cur.bt), .jump_i(cur.jp), .jump_target_i(cur.jt),
    .trap_i(cur.tr), .trap_vector_i(cur.tv), .mret_i(cur.mr), .epc_i(cur.ep),
    .halt_i(cur.hl), .resume_i(cur.rs), .pc_valid_o(v0), .pc_o(pc0), .pc_inc_o(inc0),
    .redirect_o(r0), .misaligned_o(mi0), .misaligned_addr_o(ma0));

  panda_pc_unit #(.Width(32), .ResetVector(32'h100), .CompressedEn(1'b1)) dut1 (
    .clk_i(clk), .rst_ni(cur.rst_n), .fetch_ready_i(cur.rdy), .compressed_i(cur.cmp),
    .branch_i(cur.br), .branch_target_i(cur.bt), .jump_i(cur.jp), .jump_target_i(cur.jt),
    .trap_i(cur.tr), .trap_vector_i(cur.tv), .mret_i(cur.mr), .epc_i(cur.ep),
    .halt_i(cur.hl), .resume_i(cur.rs), .pc_valid_o(v1), .pc_o(pc1), .pc_inc_o(inc1),
    .redirect_o(r1), .misaligned_o(mi1), .misaligned_addr_o(ma1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t S(bit rn, bit rdy, bit cmp, bit tr, bit mr, bit jp, bit br,
                              bit hl, bit rs, logic [31:0] tv, logic [31:0] ep,
                              logic [31:0] jt, logic [31:0] bt);
    stim_t s;
    s.rst_n = rn; s.rdy = rdy; s.cmp = cmp; s.tr = tr; s.mr = mr; s.jp = jp; s.br = br;
    s.hl = hl; s.rs = rs; s.tv = tv; s.ep = ep; s.jt = jt; s.bt = bt;
    return s;
  endfunction

  task automatic add(string nm, stim_t s, logic [31:0] pc, bit v, bit r, bit m,
                     logic [31:0] ma);
    vec_t e;
    e.name = nm; e.s = s; e.pc = pc; e.valid = v; e.redir = r; e.mis = m; e.maddr = ma;
    tbl.push_back(e);
  endtask

  // Reference model: architectural rules with plain arithmetic.
  function automatic model_t mstep(model_t m, bit ce, stim_t s);
    model_t n;
    logic [31:0] al;
    al = ce ? 32'd2 : 32'd4;
    n = m;
    n.redir = 1'b0;
    n.mis = 1'b0;
    if (!s.rst_n) begin
      n.st = M_BOOT; n.pc = 32'h100; n.maddr = 32'h0;
      return n;
    end
    if (s.tr) begin
      n.pc = s.tv - (s.tv % al); n.redir = 1'b1;
    end else if (s.mr) begin
      n.pc = s.ep - (s.ep % al); n.redir = 1'b1;
    end else if (s.jp) begin
      if (s.jt % al != 0) begin n.mis = 1'b1; n.maddr = s.jt; end
      else begin n.pc = s.jt; n.redir = 1'b1; end
    end else if (s.br) begin
      if (s.bt % al != 0) begin n.mis = 1'b1; n.maddr = s.bt; end
      else begin n.pc = s.bt; n.redir = 1'b1; end
    end else if (m.st == M_RUN && s.rdy) begin
      n.pc = m.pc + ((ce && s.cmp) ? 32'd2 : 32'd4);
    end
    if (s.tr)                n.st = M_RUN;
    else if (m.st == M_BOOT) n.st = M_RUN;
    else if (m.st == M_RUN)  n.st = s.hl ? M_HALT : M_RUN;
    else                     n.st = (s.rs && !s.hl) ? M_RUN : M_HALT;
    return n;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", nm, act, exp);
    end
  endtask

  // Advance one clock; models follow the same stimulus.
  task automatic tick();
    @(posedge clk);
    m0 = mstep(m0, 1'b0, cur);
    m1 = mstep(m1, 1'b1, cur);
    #1;
  endtask

  task automatic chk_model(string tag);
    chk({tag, " d0 pc"},    pc0, m0.pc);
    chk({tag, " d0 valid"}, 32'(v0), 32'(m0.st == M_RUN));
    chk({tag, " d0 redir"}, 32'(r0), 32'(m0.redir));
    chk({tag, " d0 mis"},   32'(mi0), 32'(m0.mis));
    chk({tag, " d0 maddr"}, ma0, m0.maddr);
    chk({tag, " d1 pc"},    pc1, m1.pc);
    chk({tag, " d1 valid"}, 32'(v1), 32'(m1.st == M_RUN));
    chk({tag, " d1 redir"}, 32'(r1), 32'(m1.redir));
    chk({tag, " d1 mis"},   32'(mi1), 32'(m1.mis));
    chk({tag, " d1 maddr"}, ma1, m1.maddr);
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    m0.st = M_BOOT; m0.pc = 32'h100; m0.redir = 0; m0.mis = 0; m0.maddr = 0;
    m1 = m0;
    cur = S(0,0,0, 0,0,0,0,0,0, 0,0,0,0);

    // ---------------- table-driven vectors, checked on dut0 ----------------
    //   name          rst rdy cmp tr mr jp br hl rs  tv          ep      jt      bt          pc     v r m maddr
    add("reset1",    S(0,1,0, 0,0,0,0,0,0, 0,0,0,0),                      32'h100,0,0,0,32'h0);
    add("reset2",    S(0,1,0, 0,0,0,0,0,0, 0,0,0,0),                      32'h100,0,0,0,32'h0);
    add("boot",      S(1,1,0, 0,0,0,0,0,0, 0,0,0,0),                      32'h100,1,0,0,32'h0);
    add("seq104",    S(1,1,0, 0,0,0,0,0,0, 0,0,0,0),                      32'h104,1,0,0,32'h0);
    add("seq108",    S(1,1,0, 0,0,0,0,0,0, 0,0,0,0),                      32'h108,1,0,0,32'h0);
    add("stall1",    S(1,0,0, 0,0,0,0,0,0, 0,0,0,0),                      32'h108,1,0,0,32'h0);
    add("stall2",    S(1,0,0, 0,0,0,0,0,0, 0,0,0,0),                      32'h108,1,0,0,32'h0);
    add("stall3",    S(1,0,0, 0,0,0,0,0,0, 0,0,0,0),                      32'h108,1,0,0,32'h0);
    add("trap_prio", S(1,0,0, 1,0,1,1,0,0, 32'h80,0,32'h200,32'h300),     32'h80, 1,1,0,32'h0);
    add("jump_prio", S(1,0,0, 0,0,1,1,0,0, 32'h80,0,32'h200,32'h300),     32'h200,1,1,0,32'h0);
    add("idle",      S(1,0,0, 0,0,0,0,0,0, 0,0,0,0),                      32'h200,1,0,0,32'h0);
    add("jmp_mis",   S(1,1,0, 0,0,1,0,0,0, 0,0,32'h202,0),                32'h200,1,0,1,32'h202);
    add("br_mis",    S(1,1,0, 0,0,0,1,0,0, 0,0,0,32'h301),                32'h200,1,0,1,32'h301);
    add("no_fallbk", S(1,1,0, 0,0,1,1,0,0, 0,0,32'h202,32'h300),          32'h200,1,0,1,32'h202);
    add("maddr_hold",S(1,0,0, 0,0,0,0,0,0, 0,0,0,0),                      32'h200,1,0,0,32'h202);
    add("mret",      S(1,0,0, 0,1,0,0,0,0, 0,32'h407,0,0),                32'h404,1,1,0,32'h202);
    add("halt_adv",  S(1,1,0, 0,0,0,0,1,0, 0,0,0,0),                      32'h408,0,0,0,32'h202);
    add("halted",    S(1,1,0, 0,0,0,0,0,0, 0,0,0,0),                      32'h408,0,0,0,32'h202);
    add("halt_br",   S(1,1,0, 0,0,0,1,0,0, 0,0,0,32'h500),                32'h500,0,1,0,32'h202);
    add("halt_res",  S(1,1,0, 0,0,0,0,1,1, 0,0,0,0),                      32'h500,0,0,0,32'h202);
    add("halt_trap", S(1,1,0, 1,0,0,0,0,0, 32'h83,0,0,0),                 32'h80, 1,1,0,32'h202);
    add("halt_jmp",  S(1,1,0, 0,0,1,0,1,0, 0,0,32'h600,0),                32'h600,0,1,0,32'h202);
    add("resume",    S(1,1,0, 0,0,0,0,0,1, 0,0,0,0),                      32'h600,1,0,0,32'h202);
    add("cmp_ign",   S(1,1,1, 0,0,0,0,0,0, 0,0,0,0),                      32'h604,1,0,0,32'h202);
    add("stall4",    S(1,0,0, 0,0,0,0,0,0, 0,0,0,0),                      32'h604,1,0,0,32'h202);
    add("rst_mid",   S(0,0,0, 0,0,1,0,0,0, 0,0,32'h700,0),                32'h100,0,0,0,32'h0);

    foreach (tbl[i]) begin
      cur = tbl[i].s;
      tick();
      chk($sformatf("vec%0d %s pc", i, tbl[i].name),    pc0, tbl[i].pc);
      chk($sformatf("vec%0d %s valid", i, tbl[i].name), 32'(v0), 32'(tbl[i].valid));
      chk($sformatf("vec%0d %s redir", i, tbl[i].name), 32'(r0), 32'(tbl[i].redir));
      chk($sformatf("vec%0d %s mis", i, tbl[i].name),   32'(mi0), 32'(tbl[i].mis));
      chk($sformatf("vec%0d %s maddr", i, tbl[i].name), ma0, tbl[i].maddr);
    end

    // ---------------- compressed increments / alignment, both instances ----------------
    cur = S(1,1,0, 0,0,0,0,0,0, 0,0,0,0); tick();
    cur = S(1,0,0, 0,0,1,0,0,0, 0,0,32'h1000,0); tick();
    chk("c_jmp d1 pc", pc1, 32'h1000);
    chk("c_jmp d1 redir", 32'(r1), 32'd1);
    cur = S(1,1,1, 0,0,0,0,0,0, 0,0,0,0); #1;
    chk("c_inc d1", inc1, 32'h1002);
    chk("c_inc d0", inc0, 32'h1004);
    tick();
    chk("c1 d1 pc", pc1, 32'h1002);
    chk("c1 d0 pc", pc0, 32'h1004);
    cur = S(1,1,0, 0,0,0,0,0,0, 0,0,0,0); tick();
    chk("c0 d1 pc", pc1, 32'h1006);
    chk("c0 d0 pc", pc0, 32'h1008);
    cur = S(1,1,1, 0,0,0,0,0,0, 0,0,0,0); tick();
    chk("c1b d1 pc", pc1, 32'h1008);
    chk("c1b d0 pc", pc0, 32'h100C);
    cur = S(1,0,0, 0,0,1,0,0,0, 0,0,32'h202,0); tick();
    chk("j202 d1 pc", pc1, 32'h202);
    chk("j202 d1 mis", 32'(mi1), 32'd0);
    chk("j202 d0 pc", pc0, 32'h100C);
    chk("j202 d0 mis", 32'(mi0), 32'd1);
    chk("j202 d0 maddr", ma0, 32'h202);
    cur = S(1,0,0, 0,0,0,1,0,0, 0,0,0,32'h201); tick();
    chk("b201 d1 pc", pc1, 32'h202);
    chk("b201 d1 mis", 32'(mi1), 32'd1);
    chk("b201 d1 maddr", ma1, 32'h201);

    // ---------------- wrap at the top of the address space ----------------
    cur = S(1,0,0, 1,0,0,0,0,0, 32'hFFFF_FFFE,0,0,0); tick();
    chk("wtrap d1 pc", pc1, 32'hFFFF_FFFE);
    chk("wtrap d0 pc", pc0, 32'hFFFF_FFFC);
    cur = S(1,1,1, 0,0,0,0,0,0, 0,0,0,0); tick();
    chk("wrap d1 pc", pc1, 32'h0);
    chk("wrap d0 pc", pc0, 32'h0);
    chk("wrap d0 valid", 32'(v0), 32'd1);

    // ---------------- randomized run against the reference model ----------------
    for (int k = 0; k < 3000; k++) begin
      stim_t s;
      s.rst_n = ($urandom_range(0, 79) != 0);
      s.rdy   = ($urandom_range(0, 9) < 7);
      s.cmp   = $urandom_range(0, 1) == 1;
      s.tr    = ($urandom_range(0, 15) == 0);
      s.mr    = ($urandom_range(0, 11) == 0);
      s.jp    = ($urandom_range(0, 7) == 0);
      s.br    = ($urandom_range(0, 7) == 0);
      s.hl    = ($urandom_range(0, 9) == 0);
      s.rs    = ($urandom_range(0, 3) == 0);
      s.tv = $urandom; s.ep = $urandom; s.jt = $urandom; s.bt = $urandom;
      if ($urandom_range(0, 2) != 0) s.jt[1:0] = 2'b00;
      if ($urandom_range(0, 2) != 0) s.bt[1:0] = 2'b00;
      cur = s;
      #1;
      chk($sformatf("rnd%0d d0 pc_inc", k), inc0, m0.pc + 32'd4);
      chk($sformatf("rnd%0d d1 pc_inc", k), inc1, m1.pc + (s.cmp ? 32'd2 : 32'd4));
      tick();
      chk_model($sformatf("rnd%0d", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
